// File: rtl/bias_loader_pkg.sv
// -----------------------------------------------------------------------------
// bias_pkg
//   Shared definitions for the bias table loader: default table geometry,
//   the loader FSM state encoding, and the bias word type.
//
//   Contents:
//     BIAS_W_DEF   : default bias word width (34)
//     N_CH_DEF     : default number of channels (4)
//     BPW_DEF      : bytes per bias word derived from BIAS_W_DEF
//     BIAS_RST_DEF : default live-table reset value
//     state_t      : loader FSM states (IDLE, LOAD, CHECK, COMMIT)
//     bias_t       : one bias word at the default width
//     bpw()        : bytes needed to carry a word of a given width
// -----------------------------------------------------------------------------
package bias_pkg;

  localparam int unsigned BIAS_W_DEF = 34;
  localparam int unsigned N_CH_DEF   = 4;

  function automatic int unsigned bpw(input int unsigned w);
    return (w + 7) / 8;
  endfunction

  localparam int unsigned BPW_DEF = bpw(BIAS_W_DEF);

  typedef logic [BIAS_W_DEF-1:0] bias_t;

  // 34'hAAAAAAAA0 truncated to 34 bits.
  localparam bias_t BIAS_RST_DEF = 34'h2AAAAAAA0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    COMMIT
  } state_t;

endpackage

// File: rtl/bias_loader_if.sv
// -----------------------------------------------------------------------------
// bias_loader_if
//   Byte stream carrying bias words into the bias loader.
//
//   Signals:
//     s_data  : stream byte
//     s_valid : byte valid (source -> loader)
//     s_ready : loader accepts a byte (loader -> source)
//
//   Modports:
//     master : byte source
//     slave  : bias loader
// -----------------------------------------------------------------------------
interface bias_loader_if;

  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/bias_loader.sv
// -----------------------------------------------------------------------------
// bias_loader
//   Writer end of the per-channel accumulator bias table. Bytes arriving on
//   the stream are assembled little-endian into a shadow table, channel 0
//   first. Once every byte of every channel has arrived, the whole shadow
//   table is copied into the live table on a single edge, so readers never
//   observe a half-updated table.
//
//   Optional feature (macro BIAS_LOADER_CHECKSUM_EN):
//     One extra byte follows the data and must equal the XOR of all data
//     bytes. On mismatch the live table is left untouched and err is set.
//     Without the macro err is tied low and LOAD goes straight to COMMIT.
//
//   Parameters:
//     N_CH     : number of channels (power of two)
//     BIAS_W   : bias word width
//     BIAS_RST : value of every live entry after reset
//
//   Ports:
//     clk      : clock, rising edge
//     rst_n    : asynchronous active-low reset
//     start    : one-cycle request to begin a load (honoured only in IDLE)
//     stream   : byte stream (s_data / s_valid / s_ready), slave side
//     bias_sel : channel select for the read port
//     bias_out : live bias of bias_sel, combinational
//     busy     : a load is in progress (start accepted, not yet finished)
//     done     : one-cycle pulse after a successful commit
//     err      : sticky checksum error, cleared by the next accepted start
// -----------------------------------------------------------------------------
module bias_loader
  import bias_pkg::*;
#(
  parameter int unsigned        N_CH     = N_CH_DEF,
  parameter int unsigned        BIAS_W   = BIAS_W_DEF,
  parameter logic [BIAS_W-1:0]  BIAS_RST = BIAS_W'(BIAS_RST_DEF)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  bias_loader_if.slave            stream,
  input  logic [$clog2(N_CH)-1:0] bias_sel,
  output logic [BIAS_W-1:0]       bias_out,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned BPW  = bpw(BIAS_W);
  localparam int unsigned BC_W = (BPW  > 1) ? $clog2(BPW)  : 1;
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BPW - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);

  typedef logic [BIAS_W-1:0] word_t;

  // ---------------------------------------------------------------------------
  // State and storage
  // ---------------------------------------------------------------------------
  state_t state;
  state_t state_nxt;

  logic [BC_W-1:0] byte_cnt;
  logic [CH_W-1:0] ch_cnt;

  word_t shadow [N_CH];
  word_t live   [N_CH];

  logic done_q;

  // FSM decode
  logic rdy;
  logic bsy;
  logic load_start;
  logic load_xfer;
  logic commit;
  logic last_byte;

`ifdef BIAS_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_ok;
  logic       chk_xfer;
  logic       err_q;
`endif

  assign last_byte = (ch_cnt == CH_LAST) && (byte_cnt == BC_LAST);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and decode; s_ready depends on state only.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    rdy        = 1'b0;
    bsy        = 1'b0;
    load_start = 1'b0;
    load_xfer  = 1'b0;
    commit     = 1'b0;
`ifdef BIAS_LOADER_CHECKSUM_EN
    chk_xfer   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          load_start = 1'b1;
          state_nxt  = LOAD;
        end
      end
      LOAD: begin
        rdy = 1'b1;
        bsy = 1'b1;
        if (stream.s_valid) begin
          load_xfer = 1'b1;
          if (last_byte) begin
`ifdef BIAS_LOADER_CHECKSUM_EN
            state_nxt = CHECK;
`else
            state_nxt = COMMIT;
`endif
          end
        end
      end
`ifdef BIAS_LOADER_CHECKSUM_EN
      CHECK: begin
        rdy = 1'b1;
        bsy = 1'b1;
        if (stream.s_valid) begin
          chk_xfer  = 1'b1;
          state_nxt = csum_ok ? COMMIT : IDLE;
        end
      end
`endif
      COMMIT: begin
        bsy       = 1'b1;
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign stream.s_ready = rdy;
  assign busy           = bsy;
  assign done           = done_q;

  // ---------------------------------------------------------------------------
  // Byte merge: the incoming byte replaces lane byte_cnt of the current
  // shadow word. The word is widened to whole bytes so the last lane can be
  // written uniformly; the cast back drops the bits above BIAS_W-1.
  // ---------------------------------------------------------------------------
  logic [BPW-1:0][7:0] lanes;
  word_t               shadow_wr;

  always_comb begin
    lanes           = (BPW*8)'(shadow[ch_cnt]);
    lanes[byte_cnt] = stream.s_data;
    shadow_wr       = BIAS_W'(lanes);
  end

  // ---------------------------------------------------------------------------
  // Counters, shadow table, live table, done pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      ch_cnt   <= '0;
      done_q   <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        shadow[i] <= '0;
        live[i]   <= BIAS_RST;
      end
    end else begin
      done_q <= 1'b0;
      if (load_start) begin
        byte_cnt <= '0;
        ch_cnt   <= '0;
      end else if (load_xfer) begin
        shadow[ch_cnt] <= shadow_wr;
        if (byte_cnt == BC_LAST) begin
          byte_cnt <= '0;
          ch_cnt   <= ch_cnt + CH_W'(1);
        end else begin
          byte_cnt <= byte_cnt + BC_W'(1);
        end
      end
      if (commit) begin
        for (int unsigned i = 0; i < N_CH; i++) begin
          live[i] <= shadow[i];
        end
        done_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional running checksum and sticky error
  // ---------------------------------------------------------------------------
`ifdef BIAS_LOADER_CHECKSUM_EN
  assign csum_ok = (stream.s_data == csum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum  <= '0;
      err_q <= 1'b0;
    end else begin
      if (load_start) begin
        csum  <= '0;
        err_q <= 1'b0;
      end else begin
        if (load_xfer) begin
          csum <= csum ^ stream.s_data;
        end
        if (chk_xfer && !csum_ok) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read port: always the committed table.
  // ---------------------------------------------------------------------------
  assign bias_out = live[bias_sel];

endmodule
